// File: rtl/pulse_meter_if.sv
// pulse_meter_if: result/handshake bundle for pulse_meter.
//   highCount   - measured high time in clock cycles
//   periodCount - measured rise-to-rise period in clock cycles
//   saturated   - a counter held at full scale during this measurement
//   overrun     - one or more results were dropped before this one
//   measValid   - result valid (producer)
//   measReady   - consumer accepts result
// master: the meter (drives results); slave: the consumer.
interface pulse_meter_if #(
    parameter int CNT_W = 16
);
    logic [CNT_W-1:0] highCount;
    logic [CNT_W-1:0] periodCount;
    logic             saturated;
    logic             overrun;
    logic             measValid;
    logic             measReady;

    modport master (
        output highCount, periodCount, saturated, overrun, measValid,
        input  measReady
    );

    modport slave (
        input  highCount, periodCount, saturated, overrun, measValid,
        output measReady
    );
endinterface

// File: rtl/pulse_meter.sv
// pulse_meter: measures high time and full period (rise to rise) of an
// already synchronous, glitch-free line, in clock cycles, and offers each
// completed measurement on a valid/ready interface.
//
// Ports:
//   clk      - clock
//   rstN     - asynchronous active-low reset
//   enable   - measurement enable; low returns the FSM to IDLE
//   inData   - filtered input signal
//   meas     - pulse_meter_if.master: highCount, periodCount, saturated,
//              overrun, measValid out; measReady in
//   timeout  - (PULSE_METER_TIMEOUT_EN only) one-cycle pulse when a stalled
//              measurement is abandoned
//
// Optional feature macro: PULSE_METER_TIMEOUT_EN. When defined, a measurement
// with no input edge for TIMEOUT cycles is abandoned without a result.
module pulse_meter #(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 65535
) (
    input  logic          clk,
    input  logic          rstN,
    input  logic          enable,
    input  logic          inData,
    pulse_meter_if.master meas
`ifdef PULSE_METER_TIMEOUT_EN
    ,
    output logic          timeout
`endif
);

    if (CNT_W < 2 || TIMEOUT < 1) begin : gBadParams
        $error("pulse_meter: CNT_W must be >= 2 and TIMEOUT >= 1");
    end

    typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state, stateNext;
    logic [CNT_W-1:0] cnt, cntNext;
    logic [CNT_W-1:0] highLatch, highLatchNext;
    logic             satFlag, satFlagNext;
    logic             prevIn;
    logic             rise, fall;
    logic             complete;

    // Completion stage: one register between the rise and the output slot.
    logic             cmpValid;
    logic [CNT_W-1:0] cmpHigh, cmpPeriod;
    logic             cmpSat;

    logic             overrunSticky;
    logic             loadRes, dropRes;

    // Counter step that sticks at full scale instead of wrapping.
    logic             cntAtMax;
    logic [CNT_W-1:0] cntInc;

    assign rise     = inData & ~prevIn;
    assign fall     = ~inData & prevIn;
    assign cntAtMax = (cnt == CNT_MAX);
    assign cntInc   = cntAtMax ? cnt : cnt + CNT_W'(1);

`ifdef PULSE_METER_TIMEOUT_EN
    localparam int IDLE_W = $clog2(TIMEOUT + 1);
    logic [IDLE_W-1:0] idleCnt;
    logic              timeoutHit;
`endif

    // NOTE: every signal assigned here gets a default first, so no path
    // through the case can leave one unassigned and infer a latch.
    always_comb begin
        stateNext     = state;
        cntNext       = cnt;
        highLatchNext = highLatch;
        satFlagNext   = satFlag;
        complete      = 1'b0;
`ifdef PULSE_METER_TIMEOUT_EN
        timeoutHit    = 1'b0;
`endif
        if (!enable) begin
            stateNext     = IDLE;
            cntNext       = '0;
            highLatchNext = '0;
            satFlagNext   = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // The partial period before the first rise is discarded.
                    if (rise) begin
                        stateNext   = HIGH;
                        cntNext     = CNT_W'(1);
                        satFlagNext = 1'b0;
                    end
                end
                HIGH: begin
                    cntNext = cntInc;
                    if (cntAtMax) satFlagNext = 1'b1;
                    if (fall) begin
                        highLatchNext = cnt;
                        stateNext     = LOW;
                    end
                end
                LOW: begin
                    if (rise) begin
                        complete    = 1'b1;
                        cntNext     = CNT_W'(1);
                        satFlagNext = 1'b0;
                        stateNext   = HIGH;
                    end else begin
                        cntNext = cntInc;
                        if (cntAtMax) satFlagNext = 1'b1;
                    end
                end
                default: begin
                    stateNext = IDLE;
                    cntNext   = '0;
                end
            endcase
`ifdef PULSE_METER_TIMEOUT_EN
            // Abandon a measurement whose line has not moved for TIMEOUT cycles.
            if ((state == HIGH || state == LOW) && !rise && !fall &&
                idleCnt == IDLE_W'(TIMEOUT - 1)) begin
                stateNext     = IDLE;
                cntNext       = '0;
                highLatchNext = '0;
                satFlagNext   = 1'b0;
                timeoutHit    = 1'b1;
            end
`endif
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // here samples the values from before the clock edge.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state     <= IDLE;
            cnt       <= '0;
            highLatch <= '0;
            satFlag   <= 1'b0;
            prevIn    <= 1'b0;
        end else begin
            state     <= stateNext;
            cnt       <= cntNext;
            highLatch <= highLatchNext;
            satFlag   <= satFlagNext;
            prevIn    <= inData;
        end
    end

    // NOTE: result data registers are reset as well, so a reset mid-handshake
    // presents zeros rather than stale measurements.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            cmpValid  <= 1'b0;
            cmpHigh   <= '0;
            cmpPeriod <= '0;
            cmpSat    <= 1'b0;
        end else begin
            cmpValid <= complete;
            if (complete) begin
                cmpHigh   <= highLatch;
                cmpPeriod <= cnt;
                cmpSat    <= satFlag;
            end
        end
    end

    // A completed result loads when the slot is empty or is being emptied this
    // cycle; otherwise it is dropped and remembered as an overrun.
    assign loadRes = cmpValid && (!meas.measValid || meas.measReady);
    assign dropRes = cmpValid && meas.measValid && !meas.measReady;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            meas.measValid   <= 1'b0;
            meas.highCount   <= '0;
            meas.periodCount <= '0;
            meas.saturated   <= 1'b0;
            meas.overrun     <= 1'b0;
            overrunSticky    <= 1'b0;
        end else begin
            if (loadRes) begin
                meas.measValid   <= 1'b1;
                meas.highCount   <= cmpHigh;
                meas.periodCount <= cmpPeriod;
                meas.saturated   <= cmpSat;
                meas.overrun     <= overrunSticky;
                overrunSticky    <= 1'b0;
            end else if (meas.measValid && meas.measReady) begin
                meas.measValid <= 1'b0;
            end
            if (dropRes) overrunSticky <= 1'b1;
        end
    end

`ifdef PULSE_METER_TIMEOUT_EN
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            idleCnt <= '0;
            timeout <= 1'b0;
        end else begin
            timeout <= timeoutHit;
            if (stateNext == IDLE || rise || fall) idleCnt <= '0;
            else                                   idleCnt <= idleCnt + IDLE_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_pulse_meter.sv
// tb_pulse_meter: directed self-checking bench for pulse_meter.
// A 16-bit instance covers the main behaviour; a 4-bit instance sharing the
// same stimulus covers counter saturation. Transfers are captured on the
// falling edge into queues and compared against hand-computed values.
module tb_pulse_meter;

`ifdef PULSE_METER_TIMEOUT_EN
    localparam int TO = 10;
`else
    localparam int TO = 65535;
`endif

    logic clk = 1'b0;
    logic rstN;
    logic enable;
    logic inData;
`ifdef PULSE_METER_TIMEOUT_EN
    logic timeoutSig;
    logic timeout4;
`endif

    always #5 clk = ~clk;

    pulse_meter_if #(.CNT_W(16)) meas ();
    pulse_meter_if #(.CNT_W(4))  meas4 ();

    pulse_meter #(.CNT_W(16), .TIMEOUT(TO)) dut (
        .clk    (clk),
        .rstN   (rstN),
        .enable (enable),
        .inData (inData),
        .meas   (meas)
`ifdef PULSE_METER_TIMEOUT_EN
        ,
        .timeout(timeoutSig)
`endif
    );

    pulse_meter #(.CNT_W(4)) dut4 (
        .clk    (clk),
        .rstN   (rstN),
        .enable (enable),
        .inData (inData),
        .meas   (meas4)
`ifdef PULSE_METER_TIMEOUT_EN
        ,
        .timeout(timeout4)
`endif
    );

    typedef struct {
        int h;
        int p;
        int s;
        int o;
        int cyc;
    } res_t;

    res_t q[$];
    res_t q4[$];
    res_t rCap, rCap4;
    int   riseAt[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every transfer with the index of the edge the result appeared on.
    always @(negedge clk) begin
        if (meas.measValid === 1'b1 && meas.measReady === 1'b1) begin
            rCap.h   = int'(meas.highCount);
            rCap.p   = int'(meas.periodCount);
            rCap.s   = int'(meas.saturated);
            rCap.o   = int'(meas.overrun);
            rCap.cyc = cyc;
            q.push_back(rCap);
        end
        if (meas4.measValid === 1'b1 && meas4.measReady === 1'b1) begin
            rCap4.h   = int'(meas4.highCount);
            rCap4.p   = int'(meas4.periodCount);
            rCap4.s   = int'(meas4.saturated);
            rCap4.o   = int'(meas4.overrun);
            rCap4.cyc = cyc;
            q4.push_back(rCap4);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drive inData to v for n sampling edges; log the edge index of each rise.
    task automatic seg(input logic v, input int n);
        if (v && !inData) riseAt.push_back(cyc + 1);
        inData = v;
        tick(n);
    endtask

    task automatic doReset();
        rstN   = 1'b0;
        inData = 1'b0;
        tick(2);
        rstN = 1'b1;
        tick(1);
        q.delete();
        q4.delete();
        riseAt.delete();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rstN            = 1'b0;
        enable          = 1'b0;
        inData          = 1'b0;
        meas.measReady  = 1'b0;
        meas4.measReady = 1'b1;

        // Reset state
        #2;
        check("rst_valid",  meas.measValid,   0);
        check("rst_high",   meas.highCount,   0);
        check("rst_period", meas.periodCount, 0);
        check("rst_sat",    meas.saturated,   0);
        check("rst_ovr",    meas.overrun,     0);
        doReset();

        // 3 high / 5 low, three times: two results, valid two edges after rise
        enable         = 1'b1;
        meas.measReady = 1'b1;
        seg(0, 2);
        for (int i = 0; i < 3; i++) begin
            seg(1, 3);
            seg(0, 5);
        end
        check("p35_count", q.size(), 2);
        for (int i = 0; i < 2; i++) begin
            if (q.size() > i) begin
                check("p35_high",    q[i].h,   3);
                check("p35_period",  q[i].p,   8);
                check("p35_sat",     q[i].s,   0);
                check("p35_ovr",     q[i].o,   0);
                check("p35_latency", q[i].cyc, riseAt[i+1] + 1);
            end
        end

        // 1 high / 1 low toggling: a result on every rise
        doReset();
        seg(0, 1);
        for (int i = 0; i < 6; i++) begin
            seg(1, 1);
            seg(0, 1);
        end
        tick(3);
        check("tog_count", q.size(), 5);
        for (int i = 0; i < 5; i++) begin
            if (q.size() > i) begin
                check("tog_high",   q[i].h,   1);
                check("tog_period", q[i].p,   2);
                check("tog_cycle",  q[i].cyc, riseAt[i+1] + 1);
            end
        end

        // Back-pressure: first result held, two dropped, overrun on the next
        doReset();
        meas.measReady = 1'b0;
        seg(0, 1);
        for (int i = 0; i < 4; i++) begin
            seg(1, 4);
            seg(0, 4);
            if (i >= 1) begin
                check("hold_valid",  meas.measValid,   1);
                check("hold_high",   meas.highCount,   4);
                check("hold_period", meas.periodCount, 8);
                check("hold_ovr",    meas.overrun,     0);
            end
        end
        meas.measReady = 1'b1;
        seg(1, 4);
        seg(0, 4);
        seg(1, 4);
        seg(0, 4);
        check("ovr_count", q.size(), 3);
        for (int i = 0; i < 3; i++) begin
            if (q.size() > i) begin
                check("ovr_high",   q[i].h, 4);
                check("ovr_period", q[i].p, 8);
                check("ovr_flag",   q[i].o, (i == 1) ? 1 : 0);
            end
        end

        // Saturation on the 4-bit instance; the 16-bit instance sees 20/22
        doReset();
        seg(0, 1);
        seg(1, 20);
        seg(0, 2);
        seg(1, 2);
        seg(0, 2);
        seg(1, 1);
        seg(0, 1);
        tick(2);
        check("sat_count", q4.size(), 2);
        if (q4.size() >= 2) begin
            check("sat_high",     q4[0].h, 15);
            check("sat_period",   q4[0].p, 15);
            check("sat_flag",     q4[0].s, 1);
            check("sat_nxt_high", q4[1].h, 2);
            check("sat_nxt_per",  q4[1].p, 4);
            check("sat_nxt_flag", q4[1].s, 0);
        end
        check("wide_count", q.size(), 2);
        if (q.size() >= 1) begin
            check("wide_high",   q[0].h, 20);
            check("wide_period", q[0].p, 22);
            check("wide_sat",    q[0].s, 0);
        end

        // Asynchronous reset mid-HIGH while a result is pending
        doReset();
        meas.measReady = 1'b0;
        seg(0, 1);
        seg(1, 2);
        seg(0, 2);
        seg(1, 2);
        check("arst_pre_valid", meas.measValid, 1);
        #2;
        rstN   = 1'b0;
        inData = 1'b0;
        #1;
        check("arst_valid",  meas.measValid,   0);
        check("arst_high",   meas.highCount,   0);
        check("arst_period", meas.periodCount, 0);
        tick(1);
        rstN           = 1'b1;
        meas.measReady = 1'b1;
        q.delete();
        seg(0, 2);
        seg(1, 2);
        seg(0, 2);
        check("arst_nores", q.size(), 0);
        seg(1, 1);
        seg(0, 1);
        tick(2);
        check("arst_count", q.size(), 1);
        if (q.size() >= 1) begin
            check("arst_high2",   q[0].h, 2);
            check("arst_period2", q[0].p, 4);
        end

        // enable low: pending result kept, measurement restarts on a fresh rise
        doReset();
        meas.measReady = 1'b0;
        seg(0, 1);
        seg(1, 2);
        seg(0, 2);
        seg(1, 1);
        enable = 1'b0;
        tick(3);
        check("en_hold_valid", meas.measValid, 1);
        check("en_hold_high",  meas.highCount, 2);
        check("en_hold_per",   meas.periodCount, 4);
        meas.measReady = 1'b1;
        tick(1);
        check("en_xfer", q.size(), 1);
        enable = 1'b1;
        seg(1, 2);
        seg(0, 1);
        seg(1, 3);
        seg(0, 1);
        seg(1, 1);
        seg(0, 1);
        tick(2);
        check("en_count", q.size(), 2);
        if (q.size() >= 2) begin
            check("en_high",   q[1].h, 3);
            check("en_period", q[1].p, 4);
        end

`ifdef PULSE_METER_TIMEOUT_EN
        // Stuck-high line abandoned after TIMEOUT cycles
        begin
            int toCyc[$];
            int rEdge;
            doReset();
            seg(0, 2);
            rEdge  = cyc + 1;
            inData = 1'b1;
            for (int i = 0; i < 15; i++) begin
                tick(1);
                if (timeoutSig === 1'b1) toCyc.push_back(cyc);
            end
            check("to_pulses", toCyc.size(), 1);
            if (toCyc.size() >= 1) check("to_cycle", toCyc[0], rEdge + 10);
            check("to_nores", q.size(), 0);
            seg(0, 1);
            seg(1, 2);
            seg(0, 3);
            seg(1, 1);
            seg(0, 1);
            tick(2);
            check("to_count", q.size(), 1);
            if (q.size() >= 1) begin
                check("to_high",   q[0].h, 2);
                check("to_period", q[0].p, 5);
            end
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
